// File: rtl/sram_req_bridge_if.sv
// Request/response stream between a cache/DMA-style master and the SRAM bridge.
// The master issues requests and consumes read data; the bridge is the slave.
interface sram_req_bridge_if #(
    parameter int AW         = 10,
    parameter int DATA_WIDTH = 64
);
    localparam int BE_W = (DATA_WIDTH + 7) / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AW-1:0]         req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_W-1:0]       req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_bridge.sv
// Initiator side of a single-port SRAM with 1-cycle read latency: turns a
// valid/ready request stream into SRAM cycles and queues read data for the consumer.
module sram_req_bridge #(
    parameter int  NUM_WORDS  = 1024,
    parameter int  DATA_WIDTH = 64,
    parameter int  RSP_DEPTH  = 3,
    parameter bit  INIT_ZERO  = 1'b0,
    localparam int BE_W       = (DATA_WIDTH + 7) / 8,
    localparam int AW         = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sram_req_bridge_if.slave      bus,
    output logic                  init_done_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BE_W-1:0]       sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          init_done_q;

    logic                  inflight_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    logic req_ready;
    logic accept;
    logic push;
    logic pop;
    logic rsp_valid;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (INIT_ZERO) begin
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == AW'(NUM_WORDS - 1)) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                        clr_cnt_q   <= '0;
                    end
                end
                ST_READY: state_q <= ST_READY;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_done_o = init_done_q;

    // In-flight reads hold a credit so a push never meets a full FIFO.
    assign req_ready     = (state_q == ST_READY) &&
                           ((int'(count_q) + int'(inflight_q)) < RSP_DEPTH);
    assign accept        = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;

    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (state_q == ST_CLEAR) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = clr_cnt_q;
            sram_be_o   = '1;
        end else if (accept) begin
            sram_req_o   = 1'b1;
            sram_we_o    = bus.req_we;
            sram_addr_o  = bus.req_addr;
            sram_wdata_o = bus.req_wdata;
            sram_be_o    = bus.req_be;
        end
    end

    assign push      = inflight_q;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && bus.rsp_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= accept && !bus.req_we;
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // NOTE: the data storage is deliberately not reset; only pointers and count
    // are, and the output is gated with rsp_valid so stale words never escape.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= sram_rdata_i;
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !pop) |-> (int'(count_q) < RSP_DEPTH));

endmodule

// File: tb/tb_sram_req_bridge.sv
// Scoreboard bench for sram_req_bridge: a small 5-word zero-fill instance and a
// 32-word instance, each attached to a behavioural SRAM with byte enables.
module tb_sram_req_bridge;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t        exp_b[$];
    logic [63:0] exp_a[$];

    // ---------------- instance A: 5 words, zero-fill ----------------
    sram_req_bridge_if #(.AW(3), .DATA_WIDTH(64)) a_if ();
    logic        init_done_a, sram_req_a, sram_we_a;
    logic [2:0]  sram_addr_a;
    logic [63:0] sram_wdata_a, sram_rdata_a;
    logic [7:0]  sram_be_a;
    logic [63:0] mem_a [5];

    sram_req_bridge #(.NUM_WORDS(5), .DATA_WIDTH(64), .RSP_DEPTH(3), .INIT_ZERO(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(a_if), .init_done_o(init_done_a),
        .sram_req_o(sram_req_a), .sram_we_o(sram_we_a), .sram_addr_o(sram_addr_a),
        .sram_wdata_o(sram_wdata_a), .sram_be_o(sram_be_a), .sram_rdata_i(sram_rdata_a)
    );

    // ---------------- instance B: 32 words, zero-fill ----------------
    sram_req_bridge_if #(.AW(5), .DATA_WIDTH(64)) b_if ();
    logic        init_done_b, sram_req_b, sram_we_b;
    logic [4:0]  sram_addr_b;
    logic [63:0] sram_wdata_b, sram_rdata_b;
    logic [7:0]  sram_be_b;
    logic [63:0] mem_b [32];

    sram_req_bridge #(.NUM_WORDS(32), .DATA_WIDTH(64), .RSP_DEPTH(3), .INIT_ZERO(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_if), .init_done_o(init_done_b),
        .sram_req_o(sram_req_b), .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b),
        .sram_wdata_o(sram_wdata_b), .sram_be_o(sram_be_b), .sram_rdata_i(sram_rdata_b)
    );

    // Behavioural SRAMs start with garbage so the zero-fill is observable.
    initial begin
        for (int i = 0; i < 5; i++)  mem_a[i] <= 64'hBAD0_BAD0_BAD0_0000 + 64'(i);
        for (int i = 0; i < 32; i++) mem_b[i] <= 64'hBAD1_BAD1_BAD1_0000 + 64'(i);
    end

    always @(posedge clk) begin
        if (sram_req_a) begin
            if (sram_we_a) begin
                for (int i = 0; i < 8; i++)
                    if (sram_be_a[i]) mem_a[sram_addr_a][i*8 +: 8] <= sram_wdata_a[i*8 +: 8];
            end else begin
                sram_rdata_a <= mem_a[sram_addr_a];
            end
        end
    end

    always @(posedge clk) begin
        if (sram_req_b) begin
            if (sram_we_b) begin
                for (int i = 0; i < 8; i++)
                    if (sram_be_b[i]) mem_b[sram_addr_b][i*8 +: 8] <= sram_wdata_b[i*8 +: 8];
            end else begin
                sram_rdata_b <= mem_b[sram_addr_b];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
        else n_pass++;
    endtask

    // Monitors sample 1 ns before the rising edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        #4;
        if (b_if.rsp_valid && b_if.rsp_ready) begin
            if (exp_b.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_rsp: got response %h, required no response", b_if.rsp_rdata);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                check("b_rdata", b_if.rsp_rdata, e.data);
                if (e.chk_lat) check("b_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    always @(negedge clk) begin
        #4;
        if (a_if.rsp_valid && a_if.rsp_ready) begin
            if (exp_a.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_rsp: got response %h, required no response", a_if.rsp_rdata);
            end else begin
                check("a_rdata", a_if.rsp_rdata, exp_a.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_b(input logic we, input logic [4:0] addr, input logic [63:0] wdata,
                          input logic [7:0] be, input logic [63:0] exp, input bit chk_lat);
        int guard;
        guard = 0;
        b_if.req_valid = 1'b1;
        b_if.req_we    = we;
        b_if.req_addr  = addr;
        b_if.req_wdata = wdata;
        b_if.req_be    = be;
        while (!b_if.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!b_if.req_ready) begin
            b_if.req_valid = 1'b0;
            check("b_req_accept", 64'(b_if.req_ready), 64'd1);
        end else if (!we) begin
            exp_b.push_back('{data: exp, acc: cyc, chk_lat: chk_lat});
        end
        @(negedge clk);
        b_if.req_valid = 1'b0;
    endtask

    task automatic send_a_read(input logic [2:0] addr, input logic [63:0] exp);
        int guard;
        guard = 0;
        a_if.req_valid = 1'b1;
        a_if.req_we    = 1'b0;
        a_if.req_addr  = addr;
        while (!a_if.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!a_if.req_ready) begin
            a_if.req_valid = 1'b0;
            check("a_req_accept", 64'(a_if.req_ready), 64'd1);
        end else begin
            exp_a.push_back(exp);
        end
        @(negedge clk);
        a_if.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(exp_a.size() + exp_b.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_b_init();
        int guard;
        guard = 0;
        while (!init_done_b && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("b_init_done", 64'(init_done_b), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        rst_n = 1'b0;
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0;
        a_if.req_wdata = '0;   a_if.req_be = '0;   a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0;
        b_if.req_wdata = '0;   b_if.req_be = '0;   b_if.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("a_reset_outputs", 64'({init_done_a, sram_req_a, sram_we_a, sram_addr_a, sram_be_a,
                                      a_if.req_ready, a_if.rsp_valid}), 64'd0);
        check("a_reset_rdata", a_if.rsp_rdata | sram_wdata_a, 64'd0);
        check("b_reset_outputs", 64'({init_done_b, sram_req_b, b_if.req_ready, b_if.rsp_valid}), 64'd0);

        // Test 1: zero-fill of 5 words, init_done on the 7th cycle after release
        rst_n = 1'b1;
        #1;
        check("a_idle_no_sram_req", 64'({sram_req_a, a_if.req_ready}), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("a_clear_cycle", 64'({sram_req_a, sram_we_a, sram_be_a, sram_addr_a, init_done_a, a_if.req_ready}),
                  64'({1'b1, 1'b1, 8'hFF, 3'(k - 1), 1'b0, 1'b0}));
            check("a_clear_wdata", sram_wdata_a, 64'd0);
        end
        @(negedge clk);
        check("a_init_done_cycle7", 64'({init_done_a, sram_req_a}), 64'b10);
        a_if.rsp_ready = 1'b1;
        for (int i = 4; i >= 0; i--) send_a_read(3'(i), 64'd0);

        // Test 2: full write then read-back, minimum latency
        wait_b_init();
        b_if.rsp_ready = 1'b1;
        send_b(1'b1, 5'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'd0, 1'b0);
        send_b(1'b0, 5'd3, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b1);
        // Reading a never-written word returns the zero-fill value.
        send_b(1'b0, 5'd31, 64'd0, 8'h00, 64'd0, 1'b0);

        // Test 3: partial write with low four byte enables
        send_b(1'b1, 5'd5, 64'hAAAA_AAAA_BBBB_BBBB, 8'hFF, 64'd0, 1'b0);
        send_b(1'b1, 5'd5, 64'h1111_1111_2222_2222, 8'h0F, 64'd0, 1'b0);
        send_b(1'b0, 5'd5, 64'd0, 8'h00, 64'hAAAA_AAAA_2222_2222, 1'b0);
        drain("b_drain_t23");

        // Test 4: 16 back-to-back reads with the consumer always ready
        for (int i = 0; i < 16; i++)
            send_b(1'b1, 5'(i), 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("b_t4_req_ready", 64'(b_if.req_ready), 64'd1);
            send_b(1'b0, 5'(i), 64'd0, 8'h00, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b1);
        end
        drain("b_drain_t4");

        // Test 5: back-pressure stops acceptance after RSP_DEPTH reads
        for (int i = 0; i < 3; i++)
            send_b(1'b1, 5'(20 + i), 64'h5555_0000_0000_0000 + 64'(i), 8'hFF, 64'd0, 1'b0);
        b_if.rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            b_if.req_valid = 1'b1;
            b_if.req_we    = 1'b0;
            b_if.req_addr  = 5'(20 + n_acc);
            if (b_if.req_ready) begin
                exp_b.push_back('{data: 64'h5555_0000_0000_0000 + 64'(n_acc), acc: cyc, chk_lat: 1'b0});
                n_acc++;
            end
            @(negedge clk);
        end
        b_if.req_valid = 1'b0;
        check("b_t5_accepts", 64'(n_acc), 64'd3);
        check("b_t5_ready_low", 64'(b_if.req_ready), 64'd0);
        b_if.rsp_ready = 1'b1;
        drain("b_drain_t5");
        check("b_t5_ready_back", 64'(b_if.req_ready), 64'd1);

        // Test 6: reset with two responses queued and one in flight
        b_if.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_if.req_valid = 1'b1;
            b_if.req_we    = 1'b0;
            b_if.req_addr  = 5'(20 + i);
            check("b_t6_ready", 64'(b_if.req_ready), 64'd1);
            @(negedge clk);
        end
        b_if.req_valid = 1'b0;
        check("b_t6_queued", 64'({b_if.rsp_valid, b_if.req_ready}), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("b_t6_rst_outputs", 64'({b_if.rsp_valid, b_if.req_ready, sram_req_b, init_done_b}), 64'd0);
        check("b_t6_rst_rdata", b_if.rsp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_if.rsp_ready = 1'b1;
        wait_b_init();
        send_b(1'b1, 5'd7, 64'h0F0F_1234_5678_F0F0, 8'hFF, 64'd0, 1'b0);
        send_b(1'b0, 5'd7, 64'd0, 8'h00, 64'h0F0F_1234_5678_F0F0, 1'b1);
        drain("b_drain_t6");
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
